// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source producing sync, active-area coordinates and line/frame markers.
// Ports: clk, rst_n, en (pixel enable), run -> HS, VS, pix_valid, x_cord, y_cord, line_start, frame_start, frame_cnt, active.
module vga_timing_gen #(
  parameter int FRAME_WIDTH     = 640,
  parameter int FRAME_HEIGHT    = 480,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int HS_POL          = 0,
  parameter int VS_POL          = 0,
  parameter int X_CORD_WIDTH    = 10,
  parameter int Y_CORD_WIDTH    = 10,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       run,
  output logic                       HS,
  output logic                       VS,
  output logic                       pix_valid,
  output logic [X_CORD_WIDTH-1:0]    x_cord,
  output logic [Y_CORD_WIDTH-1:0]    y_cord,
  output logic                       line_start,
  output logic                       frame_start,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
  output logic                       active
);

  localparam int H_TOTAL = FRAME_WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = FRAME_HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(FRAME_WIDTH);
  localparam logic [HW-1:0] HS_BEG = HW'(FRAME_WIDTH + H_FRONT);
  localparam logic [HW-1:0] HS_LST = HW'(FRAME_WIDTH + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(FRAME_HEIGHT);
  localparam logic [VW-1:0] VS_BEG = VW'(FRAME_HEIGHT + V_FRONT);
  localparam logic [VW-1:0] VS_LST = VW'(FRAME_HEIGHT + V_FRONT + V_SYNC - 1);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e                     st_q, st_d;
  logic [HW-1:0]              h_q, h_d, h_nx;
  logic [VW-1:0]              v_q, v_d, v_nx;
  logic                       last;

  logic                       hs_q, hs_d;
  logic                       vs_q, vs_d;
  logic                       pv_q, pv_d;
  logic [X_CORD_WIDTH-1:0]    x_q, x_d;
  logic [Y_CORD_WIDTH-1:0]    y_q, y_d;
  logic                       ls_q, ls_d;
  logic                       fs_q, fs_d;
  logic [FRAME_CNT_WIDTH-1:0] fc_q, fc_d;
  logic                       act_q, act_d;

  // Raster position that follows the current one.
  always_comb begin
    last = (h_q == H_LAST) && (v_q == V_LAST);
    h_nx = h_q + HW'(1);
    v_nx = v_q;
    if (h_q == H_LAST) begin
      h_nx = '0;
      v_nx = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end
  end

  // Frames are never cut: stopping only takes effect after the last position.
  always_comb begin
    st_d = st_q;
    h_d  = h_q;
    v_d  = v_q;
    unique case (st_q)
      IDLE: begin
        if (run) begin
          st_d = RUN;
          h_d  = '0;
          v_d  = '0;
        end
      end
      RUN, DRAIN: begin
        if (last && !run) begin
          st_d = IDLE;
          h_d  = '0;
          v_d  = '0;
        end else begin
          st_d = run ? RUN : DRAIN;
          h_d  = h_nx;
          v_d  = v_nx;
        end
      end
      default: begin
        st_d = IDLE;
        h_d  = '0;
        v_d  = '0;
      end
    endcase
  end

  // Decode the upcoming position so outputs leave straight from flops.
  always_comb begin
    act_d = (st_d != IDLE);
    pv_d  = act_d && (h_d < H_ACT) && (v_d < V_ACT);
    x_d   = pv_d ? X_CORD_WIDTH'(h_d) : '0;
    y_d   = pv_d ? Y_CORD_WIDTH'(v_d) : '0;
    hs_d  = ~HS_ON;
    if (act_d && (h_d >= HS_BEG) && (h_d <= HS_LST)) begin
      hs_d = HS_ON;
    end
    vs_d  = ~VS_ON;
    if (act_d && (v_d >= VS_BEG) && (v_d <= VS_LST)) begin
      vs_d = VS_ON;
    end
    ls_d  = act_d && (h_d == '0) && (v_d < V_ACT);
    fs_d  = act_d && (h_d == '0) && (v_d == '0);
    fc_d  = fs_d ? fc_q + FRAME_CNT_WIDTH'(1) : fc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= ~HS_ON;
      vs_q  <= ~VS_ON;
      pv_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      fc_q  <= '0;
      act_q <= 1'b0;
    end else if (en) begin
      st_q  <= st_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      pv_q  <= pv_d;
      x_q   <= x_d;
      y_q   <= y_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
      fc_q  <= fc_d;
      act_q <= act_d;
    end
  end

  assign HS          = hs_q;
  assign VS          = vs_q;
  assign pix_valid   = pv_q;
  assign x_cord      = x_q;
  assign y_cord      = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fc_q;
  assign active      = act_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen on a shrunken raster.
// Raster: 8x6 active, H 2/3/2 (total 15), V 1/2/1 (total 10), 4-bit frame counter.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       run;
  logic       HS;
  logic       VS;
  logic       pix_valid;
  logic [9:0] x_cord;
  logic [9:0] y_cord;
  logic       line_start;
  logic       frame_start;
  logic [3:0] frame_cnt;
  logic       active;

  int n_cmp = 0;
  int n_bad = 0;
  int ph = 0;
  int pv = 0;
  int fc = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .FRAME_WIDTH(8),
    .FRAME_HEIGHT(6),
    .H_FRONT(2),
    .H_SYNC(3),
    .H_BACK(2),
    .V_FRONT(1),
    .V_SYNC(2),
    .V_BACK(1),
    .HS_POL(0),
    .VS_POL(0),
    .X_CORD_WIDTH(10),
    .Y_CORD_WIDTH(10),
    .FRAME_CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .run(run),
    .HS(HS),
    .VS(VS),
    .pix_valid(pix_valid),
    .x_cord(x_cord),
    .y_cord(y_cord),
    .line_start(line_start),
    .frame_start(frame_start),
    .frame_cnt(frame_cnt),
    .active(active)
  );

  task automatic cmp(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s at (%0d,%0d): observed %0d expected %0d",
             tag, ph, pv, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_run();
    logic e_pv;
    e_pv = (ph < 8) && (pv < 6);
    cmp("pix_valid", 32'(pix_valid), 32'(e_pv));
    cmp("x_cord", 32'(x_cord), e_pv ? ph : 0);
    cmp("y_cord", 32'(y_cord), e_pv ? pv : 0);
    cmp("HS", 32'(HS), (ph >= 10 && ph <= 12) ? 0 : 1);
    cmp("VS", 32'(VS), (pv == 7 || pv == 8) ? 0 : 1);
    cmp("line_start", 32'(line_start), (ph == 0 && pv < 6) ? 1 : 0);
    cmp("frame_start", 32'(frame_start), (ph == 0 && pv == 0) ? 1 : 0);
    cmp("frame_cnt", 32'(frame_cnt), fc);
    cmp("active", 32'(active), 1);
  endtask

  task automatic check_idle();
    cmp("idle_HS", 32'(HS), 1);
    cmp("idle_VS", 32'(VS), 1);
    cmp("idle_pix_valid", 32'(pix_valid), 0);
    cmp("idle_x_cord", 32'(x_cord), 0);
    cmp("idle_y_cord", 32'(y_cord), 0);
    cmp("idle_line_start", 32'(line_start), 0);
    cmp("idle_frame_start", 32'(frame_start), 0);
    cmp("idle_frame_cnt", 32'(frame_cnt), fc);
    cmp("idle_active", 32'(active), 0);
  endtask

  // One enabled cycle: expected position advances in raster order.
  task automatic adv();
    step();
    if (ph == 14) begin
      ph = 0;
      pv = (pv == 9) ? 0 : pv + 1;
    end else begin
      ph++;
    end
    if (ph == 0 && pv == 0) fc = (fc + 1) % 16;
    check_run();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    run   = 1'b0;
    repeat (3) step();
    check_idle();

    // Start latency out of reset.
    rst_n = 1'b1;
    run   = 1'b1;
    step();
    ph = 0;
    pv = 0;
    fc = 1;
    check_run();
    repeat (149) adv();
    cmp("last_x_clip", 32'(x_cord), 0);
    adv();
    cmp("frame2_start", 32'(frame_start), 1);

    // Enable toggling: every output holds through en=0 cycles.
    repeat (150) begin
      en = 1'b0;
      step();
      check_run();
      en = 1'b1;
      adv();
    end

    // Run frames to the counter wrap (15 -> 0).
    repeat (13 * 150) adv();
    cmp("frame_cnt_wrap", 32'(frame_cnt), 0);

    // Drop run mid-frame: frame completes, then idle.
    repeat (2 * 15 + 3) adv();
    run = 1'b0;
    while (!(ph == 14 && pv == 9)) adv();
    step();
    check_idle();
    repeat (5) step();
    check_idle();

    // Restart from idle.
    run = 1'b1;
    step();
    ph = 0;
    pv = 0;
    fc = (fc + 1) % 16;
    check_run();

    // Drop and re-raise run before the last position: seamless.
    repeat (80) adv();
    run = 1'b0;
    repeat (10) adv();
    run = 1'b1;
    while (!(ph == 14 && pv == 9)) adv();
    adv();
    cmp("seamless_frame_start", 32'(frame_start), 1);

    // Asynchronous reset mid-frame.
    repeat (20) adv();
    rst_n = 1'b0;
    #1;
    fc = 0;
    check_idle();
    step();
    check_idle();
    rst_n = 1'b1;
    step();
    ph = 0;
    pv = 0;
    fc = 1;
    check_run();
    repeat (20) adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
